// File: rtl/timer.sv
// Programmable down-counting timer with one-shot and auto-reload modes.
// Three word registers (CTRL, PRESET, COUNT) behind a simple bus; registered IRQ.
module timer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:2]  Addr,
   input  logic        We,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] MODE_RELOAD = 2'b01;

   state_t      state_q, state_d;
   logic [31:0] count_q, count_d;
   logic [31:0] preset_q, preset_d;
   logic        en_q, en_d;
   logic [1:0]  mode_q, mode_d;
   logic        im_q, im_d;
   logic        flag_q, flag_d;
   logic        irq_q, irq_d;

   logic        ctrl_wr;
   logic        preset_wr;
   logic        en_eff;

   assign ctrl_wr   = We && (Addr == ADDR_CTRL);
   assign preset_wr = We && (Addr == ADDR_PRESET);
   // While counting, a CPU write of Enable=0 stops the count on the same edge.
   assign en_eff    = ctrl_wr ? Din[0] : en_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      preset_d = preset_q;
      en_d     = en_q;
      mode_d   = mode_q;
      im_d     = im_q;
      flag_d   = flag_q;

      if (preset_wr) begin
         preset_d = Din;
      end

      case (state_q)
         S_IDLE: begin
            if (en_q) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!en_eff) begin
               state_d = S_IDLE;
            end else if (count_q > 32'd1) begin
               count_d = count_q - 32'd1;
            end else begin
               count_d = 32'd0;
               flag_d  = 1'b1;
               state_d = S_INT;
            end
         end
         S_INT: begin
            if (mode_q == MODE_RELOAD) begin
               flag_d  = 1'b0;
               state_d = S_LOAD;
            end else begin
               en_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // CPU write to CTRL overrides whatever the FSM did to CTRL this cycle.
      if (ctrl_wr) begin
         en_d   = Din[0];
         mode_d = Din[2:1];
         im_d   = Din[3];
         flag_d = 1'b0;
      end
   end

   assign irq_d = im_d & flag_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         count_q  <= 32'd0;
         preset_q <= 32'd0;
         en_q     <= 1'b0;
         mode_q   <= 2'b00;
         im_q     <= 1'b0;
         flag_q   <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         preset_q <= preset_d;
         en_q     <= en_d;
         mode_q   <= mode_d;
         im_q     <= im_d;
         flag_q   <= flag_d;
         irq_q    <= irq_d;
      end
   end

   always_comb begin
      Dout = 32'd0;
      case (Addr)
         ADDR_CTRL:   Dout = {28'd0, im_q, mode_q, en_q};
         ADDR_PRESET: Dout = preset_q;
         ADDR_COUNT:  Dout = count_q;
         default:     Dout = 32'd0;
      endcase
   end

   assign IRQ = irq_q;

endmodule
